output_drainer_q_fp32_output_mmap_m_axi_fifo: RTL and testbench

OUTPUT_DRAINER_Q_FP32_OUTPUT_MMAP_M_AXI_FIFO -- requirements
Module: output_drainer_q_fp32_output_mmap_m_axi_fifo

---
 rtl/output_drainer_q_fp32_output_mmap_m_axi_fifo.sv | 143 ++++++++++++++
 tb/tb_output_drainer_q_fp32_output_mmap_m_axi_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/output_drainer_q_fp32_output_mmap_m_axi_fifo.sv
// Show-ahead FIFO built from an addressable shift register plus a registered output stage.
// Capacity is DEPTH: DEPTH-1 entries in the shift register and one in the output register.

module output_drainer_q_fp32_output_mmap_m_axi_srl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH-1];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH-1];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;

  // Newest entry enters at index 0; the oldest of n entries sits at index n-1.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int i = 1; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i-1];
      end
      mem_d[0] = din;
    end
  end

  // The read uses the pre-shift contents, so a shift and a read on one edge stay consistent.
  always_comb begin
    dout_d = dout_q;
    if (re) begin
      dout_d = mem_q[raddr];
    end
  end

  // NOTE: mem_q has no reset; its contents are unreachable while the occupancy count is zero.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      mem_q <= mem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else if (clk_en) begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

module output_drainer_q_fp32_output_mmap_m_axi_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  output logic                  if_full_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   num_data_valid
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] SRL_MAX = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] n_srl_q;
  logic [ADDR_WIDTH-1:0] n_srl_d;
  logic                  dout_vld_q;
  logic                  dout_vld_d;
  logic                  full_n_q;
  logic                  full_n_d;

  logic                  push;
  logic                  pop;
  logic                  srl_re;
  logic [ADDR_WIDTH-1:0] srl_raddr;
  logic [DATA_WIDTH-1:0] srl_dout;

  assign push = if_write & full_n_q;
  assign pop  = if_read & dout_vld_q;

  // Refill the output stage whenever it is empty or being consumed this cycle.
  always_comb begin
    srl_re    = (n_srl_q != '0) & (~dout_vld_q | pop);
    srl_raddr = (n_srl_q == '0) ? '0 : n_srl_q - ADDR_WIDTH'(1);
  end

  always_comb begin
    n_srl_d    = n_srl_q + ADDR_WIDTH'(push) - ADDR_WIDTH'(srl_re);
    dout_vld_d = srl_re | (dout_vld_q & ~pop);
    full_n_d   = (n_srl_d != SRL_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_srl_q    <= '0;
      dout_vld_q <= 1'b0;
      full_n_q   <= 1'b1;
    end else if (clk_en) begin
      n_srl_q    <= n_srl_d;
      dout_vld_q <= dout_vld_d;
      full_n_q   <= full_n_d;
    end
  end

  output_drainer_q_fp32_output_mmap_m_axi_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .we     (push),
    .din    (if_din),
    .raddr  (srl_raddr),
    .re     (srl_re),
    .dout   (srl_dout)
  );

  assign if_dout        = srl_dout;
  assign if_empty_n     = dout_vld_q;
  assign if_full_n      = full_n_q;
  assign num_data_valid = {1'b0, n_srl_q} + CNT_W'(dout_vld_q);

endmodule

// File: tb/tb_output_drainer_q_fp32_output_mmap_m_axi_fifo.sv
// Directed scoreboard bench for the show-ahead SRL FIFO: latency, fill/overflow,
// streaming, steady push+pop, clock-enable hold and mid-operation reset.

module tb_output_drainer_q_fp32_output_mmap_m_axi_fifo;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 63;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          if_full_n;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_empty_n;
  logic          if_read;
  logic [DW-1:0] if_dout;
  logic [AW:0]   num_data_valid;

  int            checks   = 0;
  int            failures = 0;
  int            pops     = 0;
  logic [DW-1:0] sb [$];

  always #5 clk = ~clk;

  output_drainer_q_fp32_output_mmap_m_axi_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .if_full_n      (if_full_n),
    .if_write       (if_write),
    .if_din         (if_din),
    .if_empty_n     (if_empty_n),
    .if_read        (if_read),
    .if_dout        (if_dout),
    .num_data_valid (num_data_valid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, score the handshake seen this cycle, advance, check occupancy.
  task automatic do_cycle(input logic wr, input logic [DW-1:0] d, input logic rd,
                          input logic en = 1'b1);
    logic [DW-1:0] exp;
    if_write = wr;
    if_din   = d;
    if_read  = rd;
    clk_en   = en;
    #1;
    if (en) begin
      if (rd && if_empty_n) begin
        pops++;
        if (sb.size() == 0) begin
          check("spurious_valid", {63'b0, if_empty_n}, 64'd0);
        end else begin
          exp = sb.pop_front();
          check("read_data", {32'b0, if_dout}, {32'b0, exp});
        end
      end
      if (wr && if_full_n) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    check("num_data_valid", {57'b0, num_data_valid}, 64'(sb.size()));
    check("full_n", {63'b0, if_full_n}, {63'b0, sb.size() != DEPTH});
  endtask

  task automatic do_reset(input int cycles);
    reset    = 1'b1;
    if_write = 1'b0;
    if_read  = 1'b0;
    clk_en   = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty_n"}, {63'b0, if_empty_n}, 64'd0);
    check({tag, "_full_n"},  {63'b0, if_full_n},  64'd1);
    check({tag, "_dout"},    {32'b0, if_dout},    64'd0);
    check({tag, "_num"},     {57'b0, num_data_valid}, 64'd0);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 80 && sb.size() > 0; k++) do_cycle(1'b0, '0, 1'b1);
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    check({tag, "_empty_after"}, {63'b0, if_empty_n}, 64'd0);
  endtask

  initial begin
    logic [DW-1:0] saved_dout;
    logic [AW:0]   saved_num;
    logic          saved_empty_n;
    logic          saved_full_n;
    int            max_num;

    reset    = 1'b1;
    clk_en   = 1'b0;
    if_write = 1'b0;
    if_read  = 1'b0;
    if_din   = '0;
    do_reset(2);
    check_reset_state("reset");

    // Single write: count after 1 cycle, valid data after 2.
    do_cycle(1'b1, 32'hA5A5_0001, 1'b0);
    check("single_c1_empty_n", {63'b0, if_empty_n}, 64'd0);
    do_cycle(1'b0, '0, 1'b0);
    check("single_c2_empty_n", {63'b0, if_empty_n}, 64'd1);
    check("single_c2_dout", {32'b0, if_dout}, 64'hA5A5_0001);
    do_cycle(1'b0, '0, 1'b1);
    check("single_after_read_empty_n", {63'b0, if_empty_n}, 64'd0);

    // Pop of the last entry with a simultaneous push: one-cycle bubble.
    do_cycle(1'b1, 32'h55, 1'b0);
    do_cycle(1'b0, '0, 1'b0);
    do_cycle(1'b1, 32'h66, 1'b1);
    check("bubble_empty_n", {63'b0, if_empty_n}, 64'd0);
    do_cycle(1'b0, '0, 1'b0);
    check("bubble_then_valid", {63'b0, if_empty_n}, 64'd1);
    check("bubble_dout", {32'b0, if_dout}, 64'h66);
    drain("bubble");

    // Fill to capacity, attempt an overflow write, then read everything back.
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, DW'(i), 1'b0);
    check("fill_full_n", {63'b0, if_full_n}, 64'd0);
    check("fill_num", {57'b0, num_data_valid}, 64'd63);
    do_cycle(1'b1, 32'd99, 1'b0);
    check("overflow_num", {57'b0, num_data_valid}, 64'd63);
    pops = 0;
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, '0, 1'b1);
    check("fill_pop_count", 64'(pops), 64'd63);
    check("fill_empty_after", {63'b0, if_empty_n}, 64'd0);
    check("fill_sb_empty", 64'(sb.size()), 64'd0);

    // Streaming write+read every cycle.
    pops    = 0;
    max_num = 0;
    for (int i = 0; i < 200; i++) begin
      do_cycle(1'b1, DW'(i), 1'b1);
      if (int'(num_data_valid) > max_num) max_num = int'(num_data_valid);
    end
    check("stream_pop_count", 64'(pops), 64'd198);
    check("stream_max_occ_le2", {63'b0, max_num <= 2}, 64'd1);
    drain("stream");

    // Steady simultaneous push+pop at occupancy 10.
    for (int i = 0; i < 10; i++) do_cycle(1'b1, DW'(1000 + i), 1'b0);
    check("steady_start_num", {57'b0, num_data_valid}, 64'd10);
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'b1, DW'(2000 + i), 1'b1);
      check("steady_num", {57'b0, num_data_valid}, 64'd10);
    end
    drain("steady");

    // Clock enable low holds everything even with requests asserted.
    for (int i = 0; i < 7; i++) do_cycle(1'b1, DW'(3000 + i), 1'b0);
    saved_dout    = if_dout;
    saved_num     = num_data_valid;
    saved_empty_n = if_empty_n;
    saved_full_n  = if_full_n;
    check("clken_start_num", {57'b0, saved_num}, 64'd7);
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      check("clken_hold_dout",    {32'b0, if_dout},        {32'b0, saved_dout});
      check("clken_hold_num",     {57'b0, num_data_valid}, {57'b0, saved_num});
      check("clken_hold_empty_n", {63'b0, if_empty_n},     {63'b0, saved_empty_n});
      check("clken_hold_full_n",  {63'b0, if_full_n},      {63'b0, saved_full_n});
    end
    drain("clken");

    // Reset at occupancy 20 discards everything.
    for (int i = 0; i < 20; i++) do_cycle(1'b1, DW'(4000 + i), 1'b0);
    check("prereset_num", {57'b0, num_data_valid}, 64'd20);
    do_reset(1);
    check_reset_state("midreset");
    do_cycle(1'b1, 32'h1234, 1'b0);
    do_cycle(1'b0, '0, 1'b0);
    check("postreset_empty_n", {63'b0, if_empty_n}, 64'd1);
    check("postreset_dout", {32'b0, if_dout}, 64'h1234);
    drain("postreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
